// File: rtl/pmc_pkg.sv
// pmc_pkg: shared state type and counter index constants for pmc_controller
// Contents: pmc_state_t (IDLE, RUN, FROZEN, DUMP), NUM_CNT, CNT_* index map
package pmc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FROZEN, DUMP} pmc_state_t;
    localparam int NUM_CNT = 4;
    localparam logic [1:0] CNT_CYCLE = 2'd0;
    localparam logic [1:0] CNT_STALL = 2'd1;
    localparam logic [1:0] CNT_ARITH = 2'd2;
    localparam logic [1:0] CNT_MEM   = 2'd3;
endpackage

// File: rtl/pmc_counter.sv
// pmc_counter: one WIDTH-bit event counter with synchronous clear and sticky overflow flag
// Build option: PMC_SAT_EN -- saturate at all-ones instead of wrapping to 0
// Ports: clk; reset (async, active-high); i_clr zeroes count and flag, wins over i_inc;
//        i_inc counts one event; o_val current count; o_ovf set by an increment at all-ones
module pmc_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_val,
    output logic             o_ovf
);
    logic [WIDTH-1:0] r_val;
    logic             r_ovf;
    logic             w_max;
    assign w_max = &r_val;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_val <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_val <= '0;
            r_ovf <= 1'b0;
        end else if (i_inc) begin
            r_ovf <= r_ovf | w_max;
`ifdef PMC_SAT_EN
            r_val <= w_max ? r_val : r_val + 1'b1;
`else
            r_val <= r_val + 1'b1;
`endif
        end
    end
    assign o_val = r_val;
    assign o_ovf = r_ovf;
endmodule

// File: rtl/pmc_controller.sv
// pmc_controller: measurement-window controller gating four performance counters, with valid/ready readout
// Build option: PMC_SAT_EN -- counters saturate instead of wrapping (selected inside pmc_counter)
// Ports: clk; reset (async, active-high); start_i/stop_i/halt_i/clear_i window control;
//        stall_i/arith_i/mem_i event inputs; dump_i requests readout;
//        out_valid_o/out_ready_i/out_data_o/out_idx_o/out_last_o readout stream;
//        running_o/frozen_o state flags; ovf_o sticky overflow of any counter
module pmc_controller
    import pmc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             halt_i,
    input  logic             clear_i,
    input  logic             stall_i,
    input  logic             arith_i,
    input  logic             mem_i,
    input  logic             dump_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       out_idx_o,
    output logic             out_last_o,
    output logic             running_o,
    output logic             frozen_o,
    output logic             ovf_o
);
    pmc_state_t       r_state;
    pmc_state_t       w_next;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx;
    logic             r_valid;
    logic             r_running;
    logic             r_frozen;
    logic             r_last;
    logic             w_clr;
    logic [NUM_CNT-1:0] w_inc;
    logic [NUM_CNT-1:0] w_ovf;
    logic [WIDTH-1:0] w_val [NUM_CNT];
    always_comb begin
        w_next = r_state;
        w_idx  = r_idx;
        if (clear_i && r_state != DUMP) w_next = IDLE;
        else case (r_state)
            IDLE:   w_next = start_i ? RUN : IDLE;
            RUN:    w_next = (stop_i || halt_i) ? FROZEN : RUN;
            FROZEN: begin
                w_next = dump_i ? DUMP : (start_i ? RUN : FROZEN);
                w_idx  = dump_i ? 2'd0 : r_idx;
            end
            DUMP: if (out_ready_i) begin
                w_idx  = r_idx + 2'd1;
                w_next = (r_idx == 2'd3) ? FROZEN : DUMP;
            end
            default: w_next = IDLE;
        endcase
    end
    // Counters clear on clear_i, and on any entry into RUN so each window starts from zero.
    assign w_clr = (clear_i && r_state != DUMP) || (w_next == RUN && r_state != RUN);
    assign w_inc[CNT_CYCLE] = r_state == RUN;
    assign w_inc[CNT_STALL] = r_state == RUN && stall_i;
    assign w_inc[CNT_ARITH] = r_state == RUN && arith_i;
    assign w_inc[CNT_MEM]   = r_state == RUN && mem_i;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= 2'd0;
            r_valid   <= 1'b0;
            r_running <= 1'b0;
            r_frozen  <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_idx     <= w_idx;
            r_valid   <= w_next == DUMP;
            r_running <= w_next == RUN;
            r_frozen  <= w_next == FROZEN;
            r_last    <= w_next == DUMP && w_idx == 2'd3;
        end
    end
    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        pmc_counter #(.WIDTH(WIDTH)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .i_clr (w_clr),
            .i_inc (w_inc[g]),
            .o_val (w_val[g]),
            .o_ovf (w_ovf[g])
        );
    end
    assign out_valid_o = r_valid;
    assign out_data_o  = w_val[r_idx];
    assign out_idx_o   = r_idx;
    assign out_last_o  = r_last;
    assign running_o   = r_running;
    assign frozen_o    = r_frozen;
    assign ovf_o       = |w_ovf;
endmodule

// File: tb/tb_pmc_controller.sv
// tb_pmc_controller: checks a 32-bit and a 4-bit pmc_controller, driven in lockstep, against a window/count model
module tb_pmc_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_i = 1'b0, stop_i = 1'b0, halt_i = 1'b0, clear_i = 1'b0;
    logic stall_i = 1'b0, arith_i = 1'b0, mem_i = 1'b0, dump_i = 1'b0, out_ready_i = 1'b0;
    logic [31:0] b_data;
    logic [1:0]  b_idx;
    logic        b_valid, b_last, b_run, b_frz, b_ovf;
    logic [3:0]  s_data;
    logic [1:0]  s_idx;
    logic        s_valid, s_last, s_run, s_frz, s_ovf;
    int n_checks = 0;
    int n_errors = 0;
    // Model: mode 0 idle, 1 counting, 2 frozen, 3 streaming; counts are unbounded event totals.
    int     m_mode = 0;
    int     m_idx = 0;
    longint m_cnt [4];
    logic [31:0] d_big [4];
    logic [3:0]  d_small [4];
    logic [3:0]  d_last;
    int          d_n;

    always #5 clk = ~clk;

    pmc_controller #(.WIDTH(32)) u_big (
        .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i), .halt_i(halt_i),
        .clear_i(clear_i), .stall_i(stall_i), .arith_i(arith_i), .mem_i(mem_i), .dump_i(dump_i),
        .out_valid_o(b_valid), .out_ready_i(out_ready_i), .out_data_o(b_data), .out_idx_o(b_idx),
        .out_last_o(b_last), .running_o(b_run), .frozen_o(b_frz), .ovf_o(b_ovf)
    );

    pmc_controller #(.WIDTH(4)) u_small (
        .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i), .halt_i(halt_i),
        .clear_i(clear_i), .stall_i(stall_i), .arith_i(arith_i), .mem_i(mem_i), .dump_i(dump_i),
        .out_valid_o(s_valid), .out_ready_i(out_ready_i), .out_data_o(s_data), .out_idx_o(s_idx),
        .out_last_o(s_last), .running_o(s_run), .frozen_o(s_frz), .ovf_o(s_ovf)
    );

    function automatic longint exp_val(int i, int w);
        longint lim = longint'(1) << w;
`ifdef PMC_SAT_EN
        return (m_cnt[i] >= lim - 1) ? lim - 1 : m_cnt[i];
`else
        return m_cnt[i] % lim;
`endif
    endfunction

    function automatic bit exp_ovf(int w);
        for (int i = 0; i < 4; i++)
            if (m_cnt[i] >= (longint'(1) << w)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clr_model();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic idle_inputs();
        start_i = 0; stop_i = 0; halt_i = 0; clear_i = 0;
        stall_i = 0; arith_i = 0; mem_i = 0; dump_i = 0; out_ready_i = 0;
    endtask

    // Apply the window rules for the current inputs, then advance one clock.
    task automatic step();
        if (m_mode != 3 && clear_i) begin
            clr_model();
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (start_i) begin clr_model(); m_mode = 1; end
        end else if (m_mode == 1) begin
            m_cnt[0] += 1;
            m_cnt[1] += longint'(stall_i);
            m_cnt[2] += longint'(arith_i);
            m_cnt[3] += longint'(mem_i);
            if (stop_i || halt_i) m_mode = 2;
        end else if (m_mode == 2) begin
            if (dump_i) begin m_mode = 3; m_idx = 0; end
            else if (start_i) begin clr_model(); m_mode = 1; end
        end else if (out_ready_i) begin
            if (m_idx == 3) m_mode = 2;
            m_idx = (m_idx + 1) % 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        clr_model();
        m_mode = 0;
        m_idx = 0;
    endtask

    // Streams one full dump with ready held high, capturing words from both instances.
    task automatic dump_collect();
        d_n = 0;
        d_last = 4'b0;
        dump_i = 1; out_ready_i = 1;
        step();
        dump_i = 0;
        for (int c = 0; c < 20 && d_n < 4; c++) begin
            if (b_valid) begin
                d_big[d_n] = b_data;
                d_small[d_n] = s_data;
                d_last[d_n] = b_last;
                d_n++;
            end
            step();
        end
        out_ready_i = 0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({b_valid, b_run, b_frz, b_ovf, b_last} !== 5'b0 || b_idx !== 2'd0 || b_data !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_big: got v%b r%b f%b o%b l%b idx %0d data %0d, required all 0",
                     b_valid, b_run, b_frz, b_ovf, b_last, b_idx, b_data);
        end
        n_checks++;
        if ({s_valid, s_run, s_frz, s_ovf, s_last} !== 5'b0 || s_idx !== 2'd0 || s_data !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_small: got v%b r%b f%b o%b l%b idx %0d data %0d, required all 0",
                     s_valid, s_run, s_frz, s_ovf, s_last, s_idx, s_data);
        end
    endtask

    task automatic test_stall_window();
        int k;
        int r;
        logic [31:0] eb;
        logic [3:0]  es;
        logic [31:0] tbl [4];
        tbl = '{32'd11, 32'd3, 32'd0, 32'd0};
        idle_inputs();
        start_i = 1;
        step();
        start_i = 0;
        n_checks++;
        if (b_run !== 1'b1 || b_frz !== 1'b0 || s_run !== 1'b1) begin
            n_errors++;
            $display("FAIL start_running: got run %b frozen %b, required run 1 frozen 0", b_run, b_frz);
        end
        k = 0;
        for (int i = 0; i < 10; i++) begin
            r = int'($urandom_range(9 - i));
            stall_i = (k < 3) && (r < 3 - k);
            if (stall_i) k++;
            step();
        end
        stall_i = 0;
        stop_i = 1;
        step();
        stop_i = 0;
        n_checks++;
        if (b_frz !== 1'b1 || b_run !== 1'b0) begin
            n_errors++;
            $display("FAIL stop_frozen: got frozen %b run %b, required frozen 1 run 0", b_frz, b_run);
        end
        dump_collect();
        n_checks++;
        if (d_n !== 4 || d_last !== 4'b1000) begin
            n_errors++;
            $display("FAIL dump_shape: got %0d words last mask %b, required 4 words mask 1000", d_n, d_last);
        end
        for (int i = 0; i < 4; i++) begin
            eb = 32'(exp_val(i, 32));
            es = 4'(exp_val(i, 4));
            n_checks++;
            if (d_big[i] !== eb || d_small[i] !== es || d_big[i] !== tbl[i]) begin
                n_errors++;
                $display("FAIL stall_dump[%0d]: got %0d/%0d, required %0d/%0d (table %0d)",
                         i, d_big[i], d_small[i], eb, es, tbl[i]);
            end
        end
    endtask

    task automatic test_halt_window();
        logic [31:0] eb;
        logic [3:0]  es;
        logic [31:0] tbl [4];
        tbl = '{32'd6, 32'd0, 32'd6, 32'd6};
        start_i = 1;
        step();
        start_i = 0;
        arith_i = 1; mem_i = 1;
        repeat (5) step();
        halt_i = 1;
        step();
        halt_i = 0; arith_i = 0; mem_i = 0;
        n_checks++;
        if (b_frz !== 1'b1 || s_frz !== 1'b1) begin
            n_errors++;
            $display("FAIL halt_frozen: got frozen %b/%b, required 1/1", b_frz, s_frz);
        end
        dump_collect();
        n_checks++;
        if (d_n !== 4 || d_last !== 4'b1000) begin
            n_errors++;
            $display("FAIL halt_dump_shape: got %0d words last mask %b, required 4 words mask 1000", d_n, d_last);
        end
        for (int i = 0; i < 4; i++) begin
            eb = 32'(exp_val(i, 32));
            es = 4'(exp_val(i, 4));
            n_checks++;
            if (d_big[i] !== eb || d_small[i] !== es || d_big[i] !== tbl[i]) begin
                n_errors++;
                $display("FAIL halt_dump[%0d]: got %0d/%0d, required %0d/%0d (table %0d)",
                         i, d_big[i], d_small[i], eb, es, tbl[i]);
            end
        end
    endtask

    task automatic test_dump_backpressure();
        int n;
        bit held;
        logic [31:0] pd;
        logic [1:0]  pi;
        logic [31:0] eb;
        logic [3:0]  es;
        dump_i = 1; out_ready_i = 0;
        step();
        dump_i = 0;
        n = 0;
        held = 0;
        pd = '0;
        pi = '0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            out_ready_i = (c % 3 == 0);
            if (held) begin
                n_checks++;
                if (b_valid !== 1'b1 || b_data !== pd || b_idx !== pi) begin
                    n_errors++;
                    $display("FAIL hold_stable: got v%b idx %0d data %0d, required v1 idx %0d data %0d",
                             b_valid, b_idx, b_data, pi, pd);
                end
            end
            eb = 32'(exp_val(m_idx, 32));
            es = 4'(exp_val(m_idx, 4));
            n_checks++;
            if (b_valid !== 1'b1 || b_idx !== 2'(m_idx) || b_data !== eb || b_last !== (m_idx == 3) ||
                s_data !== es || s_idx !== 2'(m_idx)) begin
                n_errors++;
                $display("FAIL bp_word: got v%b idx %0d data %0d/%0d last %b, required idx %0d data %0d/%0d",
                         b_valid, b_idx, b_data, s_data, b_last, m_idx, eb, es);
            end
            held = !out_ready_i;
            pd = b_data;
            pi = b_idx;
            if (out_ready_i) n++;
            step();
        end
        out_ready_i = 0;
        n_checks++;
        if (n !== 4 || b_valid !== 1'b0 || b_frz !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_end: got %0d handshakes valid %b frozen %b, required 4, 0, 1", n, b_valid, b_frz);
        end
        dump_collect();
        for (int i = 0; i < 4; i++) begin
            eb = 32'(exp_val(i, 32));
            es = 4'(exp_val(i, 4));
            n_checks++;
            if (d_n !== 4 || d_big[i] !== eb || d_small[i] !== es) begin
                n_errors++;
                $display("FAIL redump[%0d]: got %0d/%0d (%0d words), required %0d/%0d",
                         i, d_big[i], d_small[i], d_n, eb, es);
            end
        end
    endtask

    task automatic test_overflow();
        logic [3:0] es;
        logic [3:0] ec;
`ifdef PMC_SAT_EN
        ec = 4'd15;
`else
        ec = 4'd4;
`endif
        clear_i = 1;
        step();
        clear_i = 0;
        start_i = 1;
        step();
        start_i = 0;
        repeat (19) step();
        stop_i = 1;
        step();
        stop_i = 0;
        n_checks++;
        if (s_ovf !== 1'b1 || b_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_flag: got small %b big %b, required 1 and 0", s_ovf, b_ovf);
        end
        dump_collect();
        es = 4'(exp_val(0, 4));
        n_checks++;
        if (d_small[0] !== ec || d_small[0] !== es || d_big[0] !== 32'd20) begin
            n_errors++;
            $display("FAIL ovf_cycles: got small %0d big %0d, required small %0d (model %0d) big 20",
                     d_small[0], d_big[0], ec, es);
        end
        n_checks++;
        if (s_ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_sticky: got %b after dump, required 1", s_ovf);
        end
    endtask

    task automatic test_clear_priority();
        clear_i = 1; dump_i = 1;
        step();
        clear_i = 0; dump_i = 0;
        n_checks++;
        if (b_valid !== 1'b0 || b_run !== 1'b0 || b_frz !== 1'b0 || s_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_over_dump: got v%b r%b f%b ovf %b, required all 0", b_valid, b_run, b_frz, s_ovf);
        end
        step();
        n_checks++;
        if (b_valid !== 1'b0 || b_frz !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_idle_hold: got v%b f%b, required 0 0", b_valid, b_frz);
        end
        start_i = 1; stop_i = 1;
        step();
        start_i = 0;
        n_checks++;
        if (b_run !== 1'b1 || b_frz !== 1'b0) begin
            n_errors++;
            $display("FAIL start_ignores_stop: got run %b frozen %b, required 1 0", b_run, b_frz);
        end
        step();
        stop_i = 0;
        n_checks++;
        if (b_frz !== 1'b1 || d_big[0] === 32'hx) begin
            n_errors++;
            $display("FAIL stop_after_start: got frozen %b, required 1", b_frz);
        end
    endtask

    task automatic test_reset_midway();
        dump_i = 1; out_ready_i = 1;
        step();
        dump_i = 0;
        step();
        step();
        n_checks++;
        if (b_valid !== 1'b1 || b_idx !== 2'd2) begin
            n_errors++;
            $display("FAIL pre_reset_dump: got v%b idx %0d, required v1 idx 2", b_valid, b_idx);
        end
        reset = 1;
        #1;
        model_reset();
        n_checks++;
        if ({b_valid, b_run, b_frz, b_ovf, b_last} !== 5'b0 || b_idx !== 2'd0 || b_data !== 32'd0 ||
            {s_valid, s_frz, s_ovf} !== 3'b0 || s_data !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_in_dump: got v%b r%b f%b o%b l%b idx %0d data %0d, required all 0",
                     b_valid, b_run, b_frz, b_ovf, b_last, b_idx, b_data);
        end
        #1;
        reset = 0;
        out_ready_i = 0;
        @(posedge clk);
        #1;
        start_i = 1;
        step();
        start_i = 0;
        repeat (3) step();
        reset = 1;
        #1;
        model_reset();
        n_checks++;
        if (b_run !== 1'b0 || b_frz !== 1'b0 || b_data !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_in_run: got run %b frozen %b data %0d, required 0 0 0", b_run, b_frz, b_data);
        end
        #1;
        reset = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [31:0] eb;
        logic [3:0]  es;
        for (int c = 0; c < 800; c++) begin
            start_i = ($urandom_range(99) < 6);
            stop_i = ($urandom_range(99) < 5);
            halt_i = ($urandom_range(99) < 3);
            clear_i = ($urandom_range(99) < 2);
            dump_i = ($urandom_range(99) < 10);
            stall_i = 1'($urandom_range(1));
            arith_i = 1'($urandom_range(1));
            mem_i = 1'($urandom_range(1));
            out_ready_i = ($urandom_range(9) < 6);
            step();
            eb = 32'(exp_val(m_idx, 32));
            es = 4'(exp_val(m_idx, 4));
            n_checks++;
            if (b_run !== (m_mode == 1) || b_frz !== (m_mode == 2) || b_valid !== (m_mode == 3) ||
                b_ovf !== exp_ovf(32) ||
                (m_mode == 3 && (b_idx !== 2'(m_idx) || b_data !== eb || b_last !== (m_idx == 3)))) begin
                n_errors++;
                $display("FAIL rand_big @%0d: got r%b f%b v%b o%b idx %0d data %0d l%b, required mode %0d idx %0d data %0d",
                         c, b_run, b_frz, b_valid, b_ovf, b_idx, b_data, b_last, m_mode, m_idx, eb);
            end
            n_checks++;
            if (s_run !== (m_mode == 1) || s_frz !== (m_mode == 2) || s_valid !== (m_mode == 3) ||
                s_ovf !== exp_ovf(4) ||
                (m_mode == 3 && (s_idx !== 2'(m_idx) || s_data !== es || s_last !== (m_idx == 3)))) begin
                n_errors++;
                $display("FAIL rand_small @%0d: got r%b f%b v%b o%b idx %0d data %0d l%b, required mode %0d idx %0d data %0d ovf %b",
                         c, s_run, s_frz, s_valid, s_ovf, s_idx, s_data, s_last, m_mode, m_idx, es, exp_ovf(4));
            end
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_stall_window();
        test_halt_window();
        test_dump_backpressure();
        test_overflow();
        test_clear_priority();
        test_reset_midway();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
